ifu32: RTL and testbench
========================

IFU32 -- requirements
Module: ifu32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning instruction, address and PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port redirect_valid, input, 1, meaning a jump/branch target is presented this cycle.
REQ-006 SHALL have port redirect_pc, input, WIDTH, meaning the new fetch address.
REQ-007 SHALL have port imem_req, output, 1, meaning an instruction memory read request.
REQ-008 SHALL have port imem_addr, output, WIDTH, meaning the read address; stable while imem_req is high.
REQ-009 SHALL have port imem_ack, input, 1, meaning imem_rdata is valid and the request completes this cycle.
REQ-010 SHALL have port imem_rdata, input, WIDTH, meaning the returned instruction word.
REQ-011 SHALL have port inst_valid, output, 1, meaning inst/inst_pc hold a fetched instruction for the decode unit.
REQ-012 SHALL have port inst, output, WIDTH, meaning the instruction word fed to the decoder.
REQ-013 SHALL have port inst_pc, output, WIDTH, meaning the address of inst.
REQ-014 SHALL have port inst_ready, input, 1, meaning the decode stage consumes inst this cycle.
REQ-015 SHALL have port fault, output, 1, meaning misaligned-target fault (see Configuration).

Function
REQ-016 SHALL implement states FETCH, HOLD, DROP, FAULT.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ack capture imem_rdata into inst, pc into inst_pc, set inst_valid, go HOLD.
REQ-018 HOLD: imem_req=0, inst_valid=1, inst/inst_pc stable; on inst_ready, pc<=pc+4 (mod 2^WIDTH, wraps to 0), clear inst_valid, go FETCH.
REQ-019 Minimum latency: ack in the same cycle as req -> inst_valid high on the next cycle; peak throughput one instruction per 2 cycles.
REQ-020 Redirect in HOLD: pc<=redirect_pc, inst_valid cleared next cycle, go FETCH; concurrent inst_ready is ignored (no pc+4).
REQ-021 Redirect in FETCH with imem_ack same cycle: returned data discarded, pc<=redirect_pc, stay FETCH.
REQ-022 Redirect in FETCH without imem_ack: pc<=redirect_pc, go DROP.
REQ-023 DROP: imem_req=1 with the old address held until imem_ack; data discarded, inst_valid stays 0, go FETCH at new pc.
REQ-024 Redirect in DROP: pc overwritten with the latest redirect_pc, remain DROP; the last redirect wins.
REQ-025 inst_valid SHALL never be high in FETCH, DROP or FAULT.
REQ-026 imem_addr SHALL be held constant from the first cycle of a request until its ack, including across redirects.

Reset
REQ-027 On rst_n low, asynchronously: state=FETCH, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fault=0.
REQ-028 imem_req SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-029 An outstanding memory request aborted by reset is abandoned; the memory side is reset by the same rst_n.

Configuration
REQ-030 Macro IFU32_MISALIGN_CHECK_EN SHALL be the single compile option.
REQ-031 Defined: redirect with redirect_pc[1:0]!=0 -> fault=1, inst_valid=0, state FAULT (after draining any outstanding request as in DROP); FAULT issues no requests; only an aligned redirect clears fault and goes FETCH.
REQ-032 Not defined: redirect_pc[1:0] is forced to 2'b00, fault is tied to 0, and the FAULT state is absent.

Verification
REQ-033 Reset release, imem_ack immediate, rdata=32'h0000_0013, inst_ready=1 -> imem_addr 8000_0000 then 8000_0004; inst=0000_0013 with inst_pc=8000_0000.
REQ-034 Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc unchanged, imem_req=0 throughout.
REQ-035 Redirect to 32'h8000_0100 while ack stalled 3 cycles -> imem_addr stays at old address until ack, old data dropped, next request at 8000_0100.
REQ-036 pc=32'hFFFF_FFFC, consume -> next imem_addr=32'h0000_0000.
REQ-037 With IFU32_MISALIGN_CHECK_EN: redirect to 32'h8000_0102 -> fault=1, no imem_req; redirect to 32'h8000_0200 -> fault=0, fetch at 8000_0200; without the macro -> fetch at 8000_0100.
REQ-038 rst_n asserted mid-DROP -> outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu32.sv
// ifu32: single-outstanding instruction fetch unit with redirect handling.
// Optional misaligned-target fault state enabled by IFU32_MISALIGN_CHECK_EN.
module ifu32 #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] inst_pc,
   input  logic             inst_ready,
   output logic             fault
);
   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DROP
`ifdef IFU32_MISALIGN_CHECK_EN
      , FAULT
`endif
   } state_t;
   state_t state, state_n, land;
   logic [WIDTH-1:0] pc, pc_n, drop_addr, drop_addr_n, tgt, dest;
   logic capture;
   assign dest = redirect_valid ? tgt : pc;
`ifdef IFU32_MISALIGN_CHECK_EN
   logic tgt_ok;
   assign tgt = redirect_pc;
   assign tgt_ok = ~|redirect_pc[1:0];
   assign land = |dest[1:0] ? FAULT : FETCH;
   assign fault = state == FAULT;
`else
   assign tgt = redirect_pc & ~WIDTH'(3);
   assign land = dest[0] ? FETCH : FETCH;
   assign fault = 1'b0;
`endif
   assign imem_req = rst_n && (state == FETCH || state == DROP);
   // DROP keeps presenting the abandoned request's address until its ack
   assign imem_addr = state == DROP ? drop_addr : pc;
   assign inst_valid = state == HOLD;
   assign capture = state == FETCH && imem_ack && !redirect_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         pc <= RESET_PC;
         drop_addr <= '0;
         inst <= '0;
         inst_pc <= '0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         drop_addr <= drop_addr_n;
         if (capture) begin
            inst <= imem_rdata;
            inst_pc <= pc;
         end
      end
   end
   always_comb begin
      state_n = state;
      pc_n = pc;
      drop_addr_n = drop_addr;
      case (state)
         FETCH: begin
            if (redirect_valid) begin
               pc_n = tgt;
               drop_addr_n = pc;
               state_n = imem_ack ? land : DROP;
            end else if (imem_ack) begin
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_n = tgt;
               state_n = land;
            end else if (inst_ready) begin
               pc_n = pc + WIDTH'(4);
               state_n = FETCH;
            end
         end
         DROP: begin
            pc_n = dest;
            state_n = imem_ack ? land : DROP;
         end
`ifdef IFU32_MISALIGN_CHECK_EN
         FAULT: begin
            if (redirect_valid && tgt_ok) begin
               pc_n = tgt;
               state_n = FETCH;
            end
         end
`endif
         default: state_n = FETCH;
      endcase
   end
endmodule

// File: tb/tb_ifu32.sv
// tb_ifu32: table-driven cycle vectors plus hand-written reset/fault sequences.
module tb_ifu32;
   logic clk = 1'b0;
   logic rst_n, redirect_valid, imem_ack, inst_ready;
   logic [31:0] redirect_pc, imem_rdata;
   logic imem_req, inst_valid, fault;
   logic [31:0] imem_addr, inst, inst_pc;
   int tests = 0, errors = 0;
   logic [31:0] cur;

   always #5 clk = ~clk;

   ifu32 dut (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .fault(fault)
   );

   typedef struct {
      logic rv; logic [31:0] rpc; logic ack; logic [31:0] rdata; logic rdy;
      logic req; logic [31:0] addr; logic iv; logic [31:0] inst; logic [31:0] ipc; logic flt;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(logic rv, logic [31:0] rpc, logic ack, logic [31:0] rdata, logic rdy,
                               logic req, logic [31:0] addr, logic iv, logic [31:0] i, logic [31:0] ipc, logic flt);
      mk = '{rv, rpc, ack, rdata, rdy, req, addr, iv, i, ipc, flt};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_iv", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_ipc", inst_pc, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
   endtask

   // drive at negedge, sample 1ns later, then advance one full cycle
   task automatic apply(vec_t v);
      redirect_valid = v.rv; redirect_pc = v.rpc; imem_ack = v.ack; imem_rdata = v.rdata; inst_ready = v.rdy;
      #1;
      chk("imem_req", {31'd0, imem_req}, {31'd0, v.req});
      if (v.req) chk("imem_addr", imem_addr, v.addr);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, v.iv});
      if (v.iv) begin
         chk("inst", inst, v.inst);
         chk("inst_pc", inst_pc, v.ipc);
      end
      chk("fault", {31'd0, fault}, {31'd0, v.flt});
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [31:0] B = 32'h8000_0000;
   localparam logic O = 1'b1, Z = 1'b0;

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      // basic fetch with immediate ack
      vecs.push_back(mk(Z, 0, O, 32'h13, Z,        O, B, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, Z, 0, O,             Z, 0, O, 32'h13, B, Z));
      vecs.push_back(mk(Z, 0, Z, 0, Z,             O, B + 4, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, O, 32'hAAAA_0001, Z, O, B + 4, Z, 0, 0, Z));
      // five cycles of backpressure, then consume
      for (int i = 0; i < 5; i++) vecs.push_back(mk(Z, 0, Z, 0, Z, Z, 0, O, 32'hAAAA_0001, B + 4, Z));
      vecs.push_back(mk(Z, 0, Z, 0, O,             Z, 0, O, 32'hAAAA_0001, B + 4, Z));
      // redirect while ack stalls three cycles
      vecs.push_back(mk(O, B + 32'h100, Z, 0, Z,   O, B + 8, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, Z, 0, Z,             O, B + 8, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, Z, 0, Z,             O, B + 8, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, O, 32'hDEAD_BEEF, Z, O, B + 8, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, O, 32'h1111_2222, Z, O, B + 32'h100, Z, 0, 0, Z));
      // redirect in HOLD beats inst_ready
      vecs.push_back(mk(O, B + 32'h40, Z, 0, O,    Z, 0, O, 32'h1111_2222, B + 32'h100, Z));
      // redirect with ack in FETCH discards the data
      vecs.push_back(mk(O, B + 32'h80, O, 32'hBAD, Z, O, B + 32'h40, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, Z, 0, Z,             O, B + 32'h80, Z, 0, 0, Z));
      // two redirects across DROP, last one wins
      vecs.push_back(mk(O, B + 32'h200, Z, 0, Z,   O, B + 32'h80, Z, 0, 0, Z));
      vecs.push_back(mk(O, B + 32'h300, Z, 0, Z,   O, B + 32'h80, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, O, 32'hBAD2, Z,      O, B + 32'h80, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, O, 32'h3333_4444, Z, O, B + 32'h300, Z, 0, 0, Z));
      // pc wrap at the top of the address space
      vecs.push_back(mk(O, 32'hFFFF_FFFC, Z, 0, Z, Z, 0, O, 32'h3333_4444, B + 32'h300, Z));
      vecs.push_back(mk(Z, 0, O, 32'h5555_6666, Z, O, 32'hFFFF_FFFC, Z, 0, 0, Z));
      vecs.push_back(mk(Z, 0, Z, 0, O,             Z, 0, O, 32'h5555_6666, 32'hFFFF_FFFC, Z));
      vecs.push_back(mk(Z, 0, Z, 0, Z,             O, 32'h0, Z, 0, 0, Z));

      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      foreach (vecs[i]) apply(vecs[i]);

      // misaligned redirect from HOLD
      apply(mk(Z, 0, O, 32'h7, Z, O, 32'h0, Z, 0, 0, Z));
      apply(mk(O, B + 32'h102, Z, 0, Z, Z, 0, O, 32'h7, 32'h0, Z));
`ifdef IFU32_MISALIGN_CHECK_EN
      apply(mk(Z, 0, Z, 0, Z, Z, 0, Z, 0, 0, O));
      apply(mk(O, B + 32'h106, Z, 0, Z, Z, 0, Z, 0, 0, O));
      apply(mk(O, B + 32'h200, Z, 0, Z, Z, 0, Z, 0, 0, O));
      cur = B + 32'h200;
`else
      cur = B + 32'h100;
`endif
      apply(mk(Z, 0, Z, 0, Z, O, cur, Z, 0, 0, Z));
      // enter DROP, then reset asynchronously mid-cycle
      apply(mk(O, B + 32'h400, Z, 0, Z, O, cur, Z, 0, 0, Z));
      apply(mk(Z, 0, Z, 0, Z, O, cur, Z, 0, 0, Z));
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(Z, 0, O, 32'h9, Z, O, B, Z, 0, 0, Z));
      apply(mk(Z, 0, Z, 0, Z, Z, 0, O, 32'h9, B, Z));

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
